// File: rtl/word_merge_arbiter_pkg.sv
// Shared constants and FSM encoding for the word merge arbiter.
// The drain depth default tracks the downstream merger's flush depth.
package word_merge_arbiter_pkg;

  localparam int SIZE_W           = 7;
  localparam int DATA_W           = 64;
  localparam int ID_W             = 3;
  localparam int MAX_REQ          = 1 << ID_W;
  localparam int CNT_W            = 8;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/word_merge_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first requester after last_idx,
// wrapping at N_REQ.
module rr_pick
  import word_merge_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_idx,
  output logic [ID_W-1:0]  next_idx,
  output logic             found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [ID_W-1:0]    cand [N_REQ];

  assign req_ext = MAX_REQ'(req);

  // cand[k] is the index k+1 positions after the previous owner
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = ID_W'((int'(last_idx) + gi + 1) % N_REQ);
    end
  endgenerate

  always_comb begin
    next_idx = last_idx;
    found    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_ext[cand[k]]) begin
        next_idx = cand[k];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_merge_arbiter.sv
// Round-robin arbiter locking one requester onto the shared word merger per
// packet, then idling DRAIN_CYCLES while the merger flushes.
module word_merge_arbiter
  import word_merge_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [SIZE_W*N_REQ-1:0]   req_size,
  input  logic [DATA_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      mrg_valid,
  output logic                      mrg_last,
  output logic [SIZE_W-1:0]         mrg_size,
  output logic [DATA_W-1:0]         mrg_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;

  logic              sel_valid;
  logic              sel_last;
  logic [SIZE_W-1:0] sel_size;
  logic [DATA_W-1:0] sel_data;
  logic              xfer;
  logic              fwd;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req      (req_valid),
    .last_idx (grant_reg),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  // Owner's request lanes; every other lane is ignored
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_size  = '0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_reg == ID_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_size  = req_size[SIZE_W*i +: SIZE_W];
        sel_data  = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign xfer = (state_reg == ST_GRANT) && sel_valid;
  // Empty non-last beats are swallowed; an empty last beat still closes the packet
  assign fwd  = xfer && ((sel_size != '0) || sel_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= ID_W'(N_REQ - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer && sel_last) begin
          state_next = ST_DRAIN;
          cnt_next   = CNT_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_reg != ST_IDLE);
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_reg == ST_GRANT) && (grant_reg == ID_W'(i));
    end
  end

  // Size and data hold their last forwarded values between beats
  always_ff @(posedge clock) begin
    if (reset) begin
      mrg_valid <= 1'b0;
      mrg_last  <= 1'b0;
      mrg_size  <= '0;
      mrg_data  <= '0;
    end else begin
      mrg_valid <= fwd;
      mrg_last  <= fwd && sel_last;
      if (fwd) begin
        mrg_size <= sel_size;
        mrg_data <= sel_data;
      end
    end
  end

  assign grant_id = grant_reg;

endmodule

// File: tb/tb_word_merge_arbiter.sv
// Self-checking bench for word_merge_arbiter: cycle table, directed packet
// sequences and randomized traffic against a packet-level reference model.
module tb_word_merge_arbiter;

  localparam int N = 4;
  localparam int D = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [7*N-1:0]  req_size = '0;
  logic [64*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            mrg_valid;
  logic            mrg_last;
  logic [6:0]      mrg_size;
  logic [63:0]     mrg_data;
  logic [2:0]      grant_id;
  logic            busy;

  word_merge_arbiter #(.N_REQ(N), .DRAIN_CYCLES(D)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_size  (req_size),
    .req_data  (req_data),
    .req_ready (req_ready),
    .mrg_valid (mrg_valid),
    .mrg_last  (mrg_last),
    .mrg_size  (mrg_size),
    .mrg_data  (mrg_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: owner (-1 when none), earliest arbitration cycle,
  // most recent owner, and the merger-side output registers.
  int          m_owner;
  int          m_next_arb;
  int          m_last_id;
  bit          m_mv, m_ml;
  logic [6:0]  m_ms;
  logic [63:0] m_md;

  typedef struct {
    int cyc;
    int id;
    int size;
    bit last;
  } beat_t;

  beat_t        beats[$];
  int           grants[$];
  logic [N-1:0] prev_rdy;
  logic [N-1:0] xfer_vec;
  int           rem[N];

  typedef struct {
    bit         v;
    bit         l;
    logic [6:0] sz;
    logic [3:0] rdy;
    bit         mv;
    logic [6:0] msz;
    bit         ml;
    bit         bsy;
    logic [2:0] gid;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_next_arb = cyc;
    m_last_id  = N - 1;
    m_mv       = 1'b0;
    m_ml       = 1'b0;
    m_ms       = '0;
    m_md       = '0;
    prev_rdy   = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_size  = '0;
    req_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Compare outputs to the model, advance one clock, advance the model.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           nxt_owner, nxt_arb, nxt_last;
    bit           p_mv, p_ml, p_upd, rst_s;
    logic [6:0]   p_ms;
    logic [63:0]  p_md;
    exp_rdy = '0;
    if (m_owner >= 0) exp_rdy[m_owner] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, (m_owner >= 0) || (cyc < m_next_arb));
    chk("grant_id", grant_id, m_last_id);
    chk("mrg_valid", mrg_valid, m_mv);
    chk("mrg_last", mrg_last, m_ml);
    chk("mrg_size", mrg_size, m_ms);
    chk("mrg_data", mrg_data, m_md);
    if (mrg_valid) beats.push_back('{cyc, int'(grant_id), int'(mrg_size), mrg_last});
    if (req_ready != '0 && prev_rdy == '0)
      for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    prev_rdy  = req_ready;
    xfer_vec  = req_valid & req_ready;
    rst_s     = reset;
    nxt_owner = m_owner;
    nxt_arb   = m_next_arb;
    nxt_last  = m_last_id;
    p_mv = 1'b0; p_ml = 1'b0; p_upd = 1'b0; p_ms = '0; p_md = '0;
    if (m_owner >= 0 && req_valid[m_owner]) begin
      if (req_size[7*m_owner +: 7] != 0 || req_last[m_owner]) begin
        p_mv  = 1'b1;
        p_ml  = req_last[m_owner];
        p_upd = 1'b1;
        p_ms  = req_size[7*m_owner +: 7];
        p_md  = req_data[64*m_owner +: 64];
      end
      if (req_last[m_owner]) begin
        nxt_owner = -1;
        nxt_arb   = cyc + D + 1;
      end
    end else if (m_owner < 0 && cyc >= m_next_arb && req_valid != '0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last_id + k) % N;
        if (req_valid[idx]) begin
          nxt_owner = idx;
          nxt_last  = idx;
          break;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (rst_s) begin
      model_reset();
    end else begin
      m_owner    = nxt_owner;
      m_next_arb = nxt_arb;
      m_last_id  = nxt_last;
      m_mv       = p_mv;
      m_ml       = p_ml;
      if (p_upd) begin
        m_ms = p_ms;
        m_md = p_md;
      end
    end
  endtask

  // Requester i presents rem[i] more beats; last on the final one
  task automatic drive_rem();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (rem[i] > 0);
      req_last[i]          = (rem[i] == 1);
      req_size[7*i +: 7]   = 7'(1 + (i * 11 + rem[i] * 5) % 63);
      req_data[64*i +: 64] = {$urandom, $urandom};
    end
  endtask

  task automatic consume();
    for (int i = 0; i < N; i++) if (xfer_vec[i] && rem[i] > 0) rem[i]--;
  endtask

  initial begin
    int t0, t1, ph, gapc, nx, nb;
    int bsz[$];
    bit blast[$];

    // Single packet from requester 2: sizes 5, 60, 3(last)
    tbl[0] = '{1'b1, 1'b0, 7'd5,  4'h0, 1'b0, 7'd0,  1'b0, 1'b0, 3'd3};
    tbl[1] = '{1'b1, 1'b0, 7'd5,  4'h4, 1'b0, 7'd0,  1'b0, 1'b1, 3'd2};
    tbl[2] = '{1'b1, 1'b0, 7'd60, 4'h4, 1'b1, 7'd5,  1'b0, 1'b1, 3'd2};
    tbl[3] = '{1'b1, 1'b1, 7'd3,  4'h4, 1'b1, 7'd60, 1'b0, 1'b1, 3'd2};
    tbl[4] = '{1'b0, 1'b0, 7'd0,  4'h0, 1'b1, 7'd3,  1'b1, 1'b1, 3'd2};
    tbl[5] = '{1'b0, 1'b0, 7'd0,  4'h0, 1'b0, 7'd3,  1'b0, 1'b1, 3'd2};
    tbl[6] = '{1'b0, 1'b0, 7'd0,  4'h0, 1'b0, 7'd3,  1'b0, 1'b1, 3'd2};
    tbl[7] = '{1'b0, 1'b0, 7'd0,  4'h0, 1'b0, 7'd3,  1'b0, 1'b0, 3'd2};

    do_reset();
    chk("rst_mrg_size", mrg_size, 0);
    chk("rst_mrg_data", mrg_data, 0);
    for (int r = 0; r < 8; r++) begin
      req_valid           = '0;
      req_last            = '0;
      req_valid[2]        = tbl[r].v;
      req_last[2]         = tbl[r].l;
      req_size[14 +: 7]   = tbl[r].sz;
      req_data[128 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(tbl[r].sz);
      chk($sformatf("tbl%0d_rdy", r), req_ready, tbl[r].rdy);
      chk($sformatf("tbl%0d_mv", r), mrg_valid, tbl[r].mv);
      chk($sformatf("tbl%0d_msz", r), mrg_size, tbl[r].msz);
      chk($sformatf("tbl%0d_ml", r), mrg_last, tbl[r].ml);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      chk($sformatf("tbl%0d_gid", r), grant_id, tbl[r].gid);
      if (tbl[r].mv)
        chk($sformatf("tbl%0d_data", r), mrg_data, 64'hC0DE_0000_0000_0000 | 64'(tbl[r].msz));
      @(posedge clock);
      #1;
    end

    // Contention: requesters 0 and 1, two beats each
    do_reset();
    grants.delete(); beats.delete();
    for (int i = 0; i < N; i++) rem[i] = 0;
    rem[0] = 2; rem[1] = 2;
    for (int c = 0; c < 40; c++) begin
      drive_rem(); step(); consume();
    end
    chk("cont_ngrants", grants.size(), 2);
    chk("cont_g0", grants.size() > 0 ? grants[0] : -1, 0);
    chk("cont_g1", grants.size() > 1 ? grants[1] : -1, 1);
    t0 = -100; t1 = -1;
    foreach (beats[k]) begin
      if (beats[k].id == 0 && beats[k].last && t0 < 0) t0 = beats[k].cyc;
      if (beats[k].id == 1 && t1 < 0) t1 = beats[k].cyc;
    end
    chk("cont_gap", (t1 - t0) >= D + 2, 1);

    // Fairness: everyone always valid with single-beat packets
    do_reset();
    grants.delete(); beats.delete();
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int c = 0; c < 400 && grants.size() < 40; c++) begin
      drive_rem(); step(); consume();
      for (int i = 0; i < N; i++) if (rem[i] == 0) rem[i] = 1;
    end
    chk("fair_count", grants.size() >= 40, 1);
    for (int k = 0; k < 40; k++)
      chk($sformatf("fair_g%0d", k), k < grants.size() ? grants[k] : -1, k % N);

    // Gap and size-0 beat on owner 1 while requester 3 waits
    do_reset();
    grants.delete(); beats.delete();
    for (int i = 0; i < N; i++) rem[i] = 0;
    rem[3] = 1; ph = 0; gapc = 0;
    for (int c = 0; c < 60; c++) begin
      drive_rem();
      req_valid[1]     = (ph == 0 || ph == 2 || ph == 3);
      req_last[1]      = (ph == 3);
      req_size[7 +: 7] = (ph == 0) ? 7'd7 : (ph == 3) ? 7'd9 : 7'd0;
      step();
      case (ph)
        0: if (xfer_vec[1]) ph = 1;
        1: begin gapc++; if (gapc == 5) ph = 2; end
        2: if (xfer_vec[1]) ph = 3;
        3: if (xfer_vec[1]) ph = 4;
        default: ;
      endcase
      consume();
    end
    chk("gap_done", (ph == 4) && (rem[3] == 0), 1);
    foreach (beats[k]) if (beats[k].id == 1) begin
      bsz.push_back(beats[k].size);
      blast.push_back(beats[k].last);
    end
    nb = bsz.size();
    chk("gap_nbeats", nb, 2);
    chk("gap_b0_size", nb > 0 ? bsz[0] : -1, 7);
    chk("gap_b1_size", nb > 1 ? bsz[1] : -1, 9);
    chk("gap_b0_last", nb > 0 ? blast[0] : 1'b1, 0);
    chk("gap_b1_last", nb > 1 ? blast[1] : 1'b0, 1);
    chk("gap_g0", grants.size() > 0 ? grants[0] : -1, 1);
    chk("gap_g1", grants.size() > 1 ? grants[1] : -1, 3);

    // Reset after the 2nd of 4 beats, then re-arbitrate from index 0
    do_reset();
    grants.delete(); beats.delete();
    for (int i = 0; i < N; i++) rem[i] = 0;
    rem[0] = 4; nx = 0;
    for (int c = 0; c < 30 && nx < 2; c++) begin
      drive_rem(); step();
      if (xfer_vec[0]) nx++;
      consume();
    end
    chk("rstm_two_beats", nx, 2);
    reset = 1'b1;
    drive_rem(); step();
    reset = 1'b0;
    chk("rstm_mrg_valid", mrg_valid, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_ready", req_ready, 0);
    chk("rstm_gid", grant_id, N - 1);
    for (int i = 0; i < N; i++) rem[i] = 0;
    rem[0] = 1; rem[3] = 1;
    grants.delete();
    for (int c = 0; c < 20; c++) begin
      drive_rem(); step(); consume();
    end
    chk("rstm_regrant", grants.size() > 0 ? grants[0] : -1, 0);

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i]         = ($urandom_range(0, 99) < 70);
        req_last[i]          = ($urandom_range(0, 99) < 30);
        req_size[7*i +: 7]   = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 63));
        req_data[64*i +: 64] = {$urandom, $urandom};
      end
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
